up_ctrl_fsm: RTL and testbench
==============================

# up_ctrl_fsm

Control unit for the 8-bit accumulator microprocessor. It sequences fetch, decode and execute by driving the datapath control strobes (IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Asel), and branches on the datapath status lines (IR[7:5], Aeq0, Apos). It also implements an operator handshake for the IN instruction. The block sits beside the datapath in the top level and is the only source of its control signals.

## Interface
Parameters:
- none; the opcode map and state encoding are fixed.

Ports:
- CLOCK  in  1  system clock, rising-edge active.
- RESET  in  1  asynchronous, active-high reset.
- IR  in  3  opcode bits [7:5] of the datapath instruction register.
- Aeq0  in  1  accumulator equals zero.
- Apos  in  1  accumulator is non-negative (bit 7 clear).
- Enter  in  1  operator "input ready" button, level; synchronous to CLOCK.
- Step  in  1  single-step request, level; ignored unless UP_CTRL_STEP_EN is defined.
- IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub  out  1 each  datapath strobes.
- Asel  out  2  accumulator source select: 2'b00 = add/sub result, 2'b01 = Input, 2'b1x = memory data.
- Halt  out  1  high while in HALT.
- State  out  4  current state code, for debug.

## Operation
- The state register is 4 bits. Encodings: START=0, FETCH=1, DECODE=2, IN_REL=3, STEP_WAIT=4, LOAD=8, STORE=9, ADD=10, SUB=11, IN=12, JZ=13, JPOS=14, HALT=15.
- Outputs are decoded combinationally from the state. JZ and JPOS additionally use Aeq0 and Apos. Any strobe not listed for a state is 0.
- Transitions and outputs per state:
  - START: all strobes 0. Next state is FETCH.
  - FETCH: Meminst=0, IRload=1, PCload=1, JMPmux=0. Effect: IR<=mem[PC], PC<=PC+1. Next state is DECODE.
  - DECODE: Meminst=1. Next state by IR: 000→LOAD, 001→STORE, 010→ADD, 011→SUB, 100→IN, 101→JZ, 110→JPOS, 111→HALT.
  - LOAD: Meminst=1, Asel=2'b10, Aload=1.
  - STORE: Meminst=1, MemWr=1.
  - ADD: Meminst=1, Asel=2'b00, Sub=0, Aload=1.
  - SUB: Meminst=1, Asel=2'b00, Sub=1, Aload=1.
  - IN:
    - While Enter=0: all strobes 0; stay in IN.
    - When Enter=1: Asel=2'b01, Aload=1; next state is IN_REL.
  - IN_REL: all strobes 0. Stay while Enter=1. Leave when Enter=0.
  - JZ: JMPmux=1, PCload=Aeq0.
  - JPOS: JMPmux=1, PCload=Apos.
  - HALT: all strobes 0, Halt=1. Absorbing; only RESET exits.
- Exit from LOAD, STORE, ADD, SUB, JZ, JPOS and IN_REL goes to the "next-fetch" state: FETCH, or STEP_WAIT in step mode.
- Unused codes 5, 6 and 7 go to START on the next clock with all strobes 0.

## Timing
- RESET asserted: State=START immediately and all outputs 0. The Step edge register clears to 0.
- RESET mid-instruction aborts the instruction. No strobe is asserted during reset.
- First FETCH happens 1 cycle after reset release.
- Latency from FETCH to the next FETCH:
  - 3 cycles for LOAD, STORE, ADD, SUB, JZ and JPOS, whether a jump is taken or not.
  - For IN: 3 cycles plus the Enter-wait cycles plus the release-wait cycles. Minimum 4 cycles: Enter already high in IN, then low in the first IN_REL cycle.
- A taken jump loads PC with IR[4:0] on the JZ/JPOS clock edge. The following FETCH reads from the target.
- Enter held high across consecutive IN instructions loads A exactly once per instruction. IN_REL guarantees this.
- Only one of MemWr or Aload is ever asserted in a given cycle. IRload and PCload are co-asserted only in FETCH.

## Configuration
- UP_CTRL_STEP_EN:
  - Defined:
    - The next-fetch state is STEP_WAIT. All strobes are 0 there.
    - STEP_WAIT moves to FETCH on a Step rising edge, i.e. Step=1 with the registered previous Step=0.
    - Holding Step high advances exactly one instruction.
  - Undefined:
    - STEP_WAIT is unreachable and Step is ignored.
    - The next-fetch state is FETCH.

## Test plan
- Reset behaviour: assert RESET with IR=3'b010 → State=0 and all strobes 0. Release → FETCH with IRload=PCload=1, then DECODE, then ADD with Aload=1, Sub=0, Asel=00.
- Full opcode sweep: feed IR=000..110 on successive instructions → the exact strobe set per execute state as listed in Operation, and FETCH-to-FETCH spacing of 3 cycles.
- Jumps:
  - JZ with Aeq0=1 → PCload=1, JMPmux=1.
  - JZ with Aeq0=0 → PCload=0.
  - JPOS with Apos=0 → PCload=0.
  - JPOS with Apos=1 → PCload=1.
- IN handshake:
  - Hold Enter=0 for 5 cycles → stays in IN with Aload=0.
  - Raise Enter → Aload=1, Asel=01 for exactly 1 cycle.
  - Hold Enter for 4 more cycles → stays in IN_REL.
  - Drop Enter → next FETCH.
- HALT and mid-instruction reset:
  - IR=111 → Halt=1 held for 20 cycles with no strobes.
  - RESET asserted in IN_REL → immediate State=0.
- Step mode (UP_CTRL_STEP_EN): after ADD, the FSM stays in STEP_WAIT. One Step pulse → exactly one instruction runs. Step held high for 10 cycles → exactly one instruction.

Source files
------------

// File: rtl/up_ctrl_fsm_if.sv
// up_ctrl_fsm_if: control strobes and status lines between up_ctrl_fsm and the datapath.
// master = control unit, slave = datapath / operator panel side.
interface up_ctrl_fsm_if;
    logic [2:0] IR;
    logic       Aeq0;
    logic       Apos;
    logic       Enter;
    logic       Step;
    logic       IRload;
    logic       JMPmux;
    logic       PCload;
    logic       Meminst;
    logic       MemWr;
    logic       Aload;
    logic       Sub;
    logic [1:0] Asel;
    logic       Halt;
    logic [3:0] State;

    modport master (
        input  IR, Aeq0, Apos, Enter, Step,
        output IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Asel, Halt, State
    );

    modport slave (
        output IR, Aeq0, Apos, Enter, Step,
        input  IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Asel, Halt, State
    );
endinterface

// File: rtl/up_ctrl_fsm.sv
// up_ctrl_fsm: fetch/decode/execute sequencer for the 8-bit accumulator CPU.
// Define UP_CTRL_STEP_EN to park in STEP_WAIT between instructions until a Step rising edge.
module up_ctrl_fsm (
    input logic           CLOCK,
    input logic           RESET,
    up_ctrl_fsm_if.master bus
);
    typedef enum logic [3:0] {
        StStart    = 4'd0,
        StFetch    = 4'd1,
        StDecode   = 4'd2,
        StInRel    = 4'd3,
        StStepWait = 4'd4,
        StLoad     = 4'd8,
        StStore    = 4'd9,
        StAdd      = 4'd10,
        StSub      = 4'd11,
        StIn       = 4'd12,
        StJz       = 4'd13,
        StJpos     = 4'd14,
        StHalt     = 4'd15
    } state_e;

    state_e state_q, state_d;
    state_e next_fetch;
    logic   step_go;

`ifdef UP_CTRL_STEP_EN
    logic step_q;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            step_q <= 1'b0;
        end else begin
            step_q <= bus.Step;
        end
    end

    assign next_fetch = StStepWait;
    // Edge detect: a held Step advances only one instruction.
    assign step_go    = bus.Step & ~step_q;
`else
    logic unused_step;
    assign unused_step = bus.Step;
    assign next_fetch  = StFetch;
    assign step_go     = 1'b1;
`endif

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q <= StStart;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bus.IRload  = 1'b0;
        bus.JMPmux  = 1'b0;
        bus.PCload  = 1'b0;
        bus.Meminst = 1'b0;
        bus.MemWr   = 1'b0;
        bus.Aload   = 1'b0;
        bus.Sub     = 1'b0;
        bus.Asel    = 2'b00;
        bus.Halt    = 1'b0;

        case (state_q)
            StStart: state_d = StFetch;
            StFetch: begin
                bus.IRload = 1'b1;
                bus.PCload = 1'b1;
                state_d    = StDecode;
            end
            StDecode: begin
                bus.Meminst = 1'b1;
                unique case (bus.IR)
                    3'b000: state_d = StLoad;
                    3'b001: state_d = StStore;
                    3'b010: state_d = StAdd;
                    3'b011: state_d = StSub;
                    3'b100: state_d = StIn;
                    3'b101: state_d = StJz;
                    3'b110: state_d = StJpos;
                    3'b111: state_d = StHalt;
                endcase
            end
            StLoad: begin
                bus.Meminst = 1'b1;
                bus.Asel    = 2'b10;
                bus.Aload   = 1'b1;
                state_d     = next_fetch;
            end
            StStore: begin
                bus.Meminst = 1'b1;
                bus.MemWr   = 1'b1;
                state_d     = next_fetch;
            end
            StAdd: begin
                bus.Meminst = 1'b1;
                bus.Aload   = 1'b1;
                state_d     = next_fetch;
            end
            StSub: begin
                bus.Meminst = 1'b1;
                bus.Sub     = 1'b1;
                bus.Aload   = 1'b1;
                state_d     = next_fetch;
            end
            StIn: begin
                if (bus.Enter) begin
                    bus.Asel  = 2'b01;
                    bus.Aload = 1'b1;
                    state_d   = StInRel;
                end
            end
            // Wait for Enter release so one press loads A only once.
            StInRel: begin
                if (!bus.Enter) begin
                    state_d = next_fetch;
                end
            end
            StStepWait: begin
                if (step_go) begin
                    state_d = StFetch;
                end
            end
            StJz: begin
                bus.JMPmux = 1'b1;
                bus.PCload = bus.Aeq0;
                state_d    = next_fetch;
            end
            StJpos: begin
                bus.JMPmux = 1'b1;
                bus.PCload = bus.Apos;
                state_d    = next_fetch;
            end
            StHalt: bus.Halt = 1'b1;
            default: state_d = StStart;
        endcase
    end

    assign bus.State = state_q;
endmodule

// File: tb/tb_up_ctrl_fsm.sv
// tb_up_ctrl_fsm: instruction-level reference model driving random opcodes, status and
// operator timing; every cycle's state and strobe set is checked against the model.
module tb_up_ctrl_fsm;
    logic CLOCK;
    logic RESET;

    up_ctrl_fsm_if bus ();

    up_ctrl_fsm dut (
        .CLOCK(CLOCK),
        .RESET(RESET),
        .bus  (bus)
    );

    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    // Strobe bit positions: {IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub}
    localparam logic [6:0] IrLd  = 7'b1000000;
    localparam logic [6:0] JmpMx = 7'b0100000;
    localparam logic [6:0] PcLd  = 7'b0010000;
    localparam logic [6:0] MemI  = 7'b0001000;
    localparam logic [6:0] MemW  = 7'b0000100;
    localparam logic [6:0] ALd   = 7'b0000010;
    localparam logic [6:0] SubS  = 7'b0000001;
    localparam logic [6:0] None  = 7'b0000000;

    int tests = 0;
    int fails = 0;

`ifdef UP_CTRL_STEP_EN
    logic step_prev = 1'b0;
    int   step_hold = 0;
`endif

    function automatic logic [13:0] mk(input logic [3:0] st, input logic halt,
                                       input logic [1:0] asel, input logic [6:0] strb);
        return {st, halt, asel, strb};
    endfunction

    task automatic check(input logic [13:0] exp, input string tag);
        logic [13:0] got;
        got = {bus.State, bus.Halt, bus.Asel, bus.IRload, bus.JMPmux, bus.PCload,
               bus.Meminst, bus.MemWr, bus.Aload, bus.Sub};
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Check one cycle at the falling edge, then move past the next rising edge.
    task automatic cyc(input logic [13:0] exp, input string tag);
        @(negedge CLOCK);
        check(exp, tag);
        @(posedge CLOCK);
`ifdef UP_CTRL_STEP_EN
        step_prev = bus.Step;
`endif
        #1;
    endtask

    task automatic rnd_status();
        bus.Aeq0  = 1'($urandom_range(0, 1));
        bus.Apos  = 1'($urandom_range(0, 1));
        bus.Enter = 1'($urandom_range(0, 1));
`ifndef UP_CTRL_STEP_EN
        bus.Step  = 1'($urandom_range(0, 1));
`endif
    endtask

    task automatic do_reset(input string tag);
        RESET = 1'b1;
        #1;
        check(mk(4'd0, 1'b0, 2'b00, None), tag);
        @(posedge CLOCK);
        #1;
        check(mk(4'd0, 1'b0, 2'b00, None), {tag, "_held"});
        RESET = 1'b0;
`ifdef UP_CTRL_STEP_EN
        step_prev = 1'b0;
`endif
        rnd_status();
        cyc(mk(4'd0, 1'b0, 2'b00, None), "start");
    endtask

    // Between instructions: nothing in free-run, Step-gated parking in step mode.
    task automatic next_fetch();
`ifdef UP_CTRL_STEP_EN
        logic go;
        go = 1'b0;
        for (int i = 0; i < step_hold + 12 && !go; i++) begin
            rnd_status();
            if (i < step_hold) bus.Step = 1'b1;
            else if (i >= step_hold + 8) bus.Step = ~step_prev;
            else bus.Step = 1'($urandom_range(0, 1));
            go = bus.Step && !step_prev;
            cyc(mk(4'd4, 1'b0, 2'b00, None), "step_wait");
        end
        step_hold = 0;
`endif
    endtask

    task automatic run_instr(input int op, input logic aeq0, input logic apos,
                             input int in_wait, input int rel_wait, input logic abort);
        rnd_status();
        bus.IR = 3'($urandom_range(0, 7));
        cyc(mk(4'd1, 1'b0, 2'b00, IrLd | PcLd), "fetch");
        rnd_status();
        bus.IR = 3'(op);
        cyc(mk(4'd2, 1'b0, 2'b00, MemI), "decode");
        rnd_status();
        case (op)
            0: cyc(mk(4'd8, 1'b0, 2'b10, MemI | ALd), "load");
            1: cyc(mk(4'd9, 1'b0, 2'b00, MemI | MemW), "store");
            2: cyc(mk(4'd10, 1'b0, 2'b00, MemI | ALd), "add");
            3: cyc(mk(4'd11, 1'b0, 2'b00, MemI | ALd | SubS), "sub");
            4: begin
                for (int i = 0; i < in_wait; i++) begin
                    rnd_status();
                    bus.Enter = 1'b0;
                    cyc(mk(4'd12, 1'b0, 2'b00, None), "in_wait");
                end
                rnd_status();
                bus.Enter = 1'b1;
                cyc(mk(4'd12, 1'b0, 2'b01, ALd), "in_load");
                for (int i = 0; i < rel_wait; i++) begin
                    rnd_status();
                    bus.Enter = 1'b1;
                    cyc(mk(4'd3, 1'b0, 2'b00, None), "in_rel_hold");
                end
                if (abort) begin
                    do_reset("reset_in_rel");
                    return;
                end
                rnd_status();
                bus.Enter = 1'b0;
                cyc(mk(4'd3, 1'b0, 2'b00, None), "in_rel_exit");
            end
            5: begin
                bus.Aeq0 = aeq0;
                cyc(mk(4'd13, 1'b0, 2'b00, JmpMx | (aeq0 ? PcLd : None)), "jz");
            end
            6: begin
                bus.Apos = apos;
                cyc(mk(4'd14, 1'b0, 2'b00, JmpMx | (apos ? PcLd : None)), "jpos");
            end
            default: begin
                for (int i = 0; i < 20; i++) begin
                    rnd_status();
                    bus.IR = 3'($urandom_range(0, 7));
                    cyc(mk(4'd15, 1'b1, 2'b00, None), "halt");
                end
                do_reset("reset_halt");
                return;
            end
        endcase
        next_fetch();
    endtask

    initial begin
        RESET     = 1'b1;
        bus.IR    = 3'b010;
        bus.Aeq0  = 1'b0;
        bus.Apos  = 1'b0;
        bus.Enter = 1'b0;
        bus.Step  = 1'b0;

        do_reset("reset");
        run_instr(2, 1'b0, 1'b0, 0, 0, 1'b0);

        for (int op = 0; op < 7; op++) begin
            run_instr(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0, 1'b0);
        end

        run_instr(5, 1'b1, 1'b0, 0, 0, 1'b0);
        run_instr(5, 1'b0, 1'b1, 0, 0, 1'b0);
        run_instr(6, 1'b1, 1'b0, 0, 0, 1'b0);
        run_instr(6, 1'b0, 1'b1, 0, 0, 1'b0);

        run_instr(4, 1'b0, 1'b0, 5, 4, 1'b0);

`ifdef UP_CTRL_STEP_EN
        // Step stays high from the last advance: ADD runs once, then Step held 10 cycles
        run_instr(2, 1'b0, 1'b0, 0, 0, 1'b0);
        step_hold = 10;
        run_instr(2, 1'b0, 1'b0, 0, 0, 1'b0);
`endif

        run_instr(4, 1'b0, 1'b0, 1, 2, 1'b1);

        for (int n = 0; n < 150; n++) begin
            run_instr($urandom_range(0, 6), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), $urandom_range(0, 3),
                      $urandom_range(0, 3), 1'b0);
        end

        run_instr(7, 1'b0, 1'b0, 0, 0, 1'b0);
        run_instr(2, 1'b0, 1'b0, 0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end
endmodule
